// File: rtl/motoro3_pkg.sv
// Shared types for the motoro3 dead-time gate: phase states, request codes, default dead band.
package motoro3_pkg;

    localparam int DEADTIME_DEFAULT = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } phase_state_e;

    typedef enum logic [1:0] {
        REQ_OFF = 2'd0,
        REQ_HI  = 2'd1,
        REQ_LO  = 2'd2
    } phase_req_e;

    localparam logic SIDE_HI = 1'b1;
    localparam logic SIDE_LO = 1'b0;

    // Low side ignores pwm: the chopping happens on the high switch only.
    function automatic phase_req_e decode_req(input logic en, input logic h1_l0, input logic pwm);
        phase_req_e r;
        r = REQ_OFF;
        if (en && h1_l0 && pwm) r = REQ_HI;
        else if (en && !h1_l0)  r = REQ_LO;
        return r;
    endfunction

    function automatic logic step_legal(input logic [3:0] step);
        return (step >= 4'd1) && (step <= 4'd6);
    endfunction

endpackage

// File: rtl/motoro3_deadtime_phase.sv
// One half-bridge: IDLE/DEAD/HI/LO FSM with a dead-band counter; gate outputs are registered
// and decided from the next state, so a request change shows on the gates one edge later.
module motoro3_deadtime_phase
    import motoro3_pkg::*;
#(
    parameter int DEADTIME = DEADTIME_DEFAULT
) (
    input  logic       clk,
    input  logic       nRst,
    input  phase_req_e i_req,
    output logic       o_hi,
    output logic       o_lo
);

    localparam logic [7:0] DT_LOAD = 8'(DEADTIME - 1);

    phase_state_e r_state;
    logic [7:0]   r_cnt;
    logic         r_last;
    logic         r_hi;
    logic         r_lo;
    logic         w_same_side;

    assign w_same_side = ((i_req == REQ_HI) && (r_last == SIDE_HI)) ||
                         ((i_req == REQ_LO) && (r_last == SIDE_LO));

    always_ff @(negedge clk) begin
        if (!nRst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_last  <= 1'b0;
            r_hi    <= 1'b0;
            r_lo    <= 1'b0;
        end else begin
            r_hi <= 1'b0;
            r_lo <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req == REQ_HI) begin
                        r_state <= ST_HI;
                        r_hi    <= 1'b1;
                    end else if (i_req == REQ_LO) begin
                        r_state <= ST_LO;
                        r_lo    <= 1'b1;
                    end
                end
                ST_HI: begin
                    if (i_req == REQ_HI) begin
                        r_hi <= 1'b1;
                    end else begin
                        r_state <= ST_DEAD;
                        r_cnt   <= DT_LOAD;
                        r_last  <= SIDE_HI;
                    end
                end
                ST_LO: begin
                    if (i_req == REQ_LO) begin
                        r_lo <= 1'b1;
                    end else begin
                        r_state <= ST_DEAD;
                        r_cnt   <= DT_LOAD;
                        r_last  <= SIDE_LO;
                    end
                end
                ST_DEAD: begin
                    // Returning to the side just left needs no dead band (pwm chopping).
                    if (w_same_side) begin
                        if (r_last == SIDE_HI) begin
                            r_state <= ST_HI;
                            r_hi    <= 1'b1;
                        end else begin
                            r_state <= ST_LO;
                            r_lo    <= 1'b1;
                        end
                    end else if (r_cnt == 8'd0) begin
                        // Expiry hands over directly so the dead band is exactly DEADTIME cycles.
                        if (i_req == REQ_HI) begin
                            r_state <= ST_HI;
                            r_hi    <= 1'b1;
                        end else if (i_req == REQ_LO) begin
                            r_state <= ST_LO;
                            r_lo    <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/motoro3_deadtime_gate.sv
// Three-phase dead-time gate: request decode, step/fault blocking, three phase FSMs.
// Optional latched fault detection is built when MOTORO3_DT_FAULT_EN is defined.
module motoro3_deadtime_gate
    import motoro3_pkg::*;
#(
    parameter int DEADTIME = DEADTIME_DEFAULT
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       pwm,
    input  logic       aE,
    input  logic       bE,
    input  logic       cE,
    input  logic       aH1_L0,
    input  logic       bH1_L0,
    input  logic       cH1_L0,
    input  logic [3:0] m3step,
    input  logic       faultClr,
    output logic       aHi,
    output logic       aLo,
    output logic       bHi,
    output logic       bLo,
    output logic       cHi,
    output logic       cLo,
    output logic       fault
);

    logic [2:0] w_en;
    logic [2:0] w_side;
    logic [2:0] w_hi;
    logic [2:0] w_lo;
    logic       w_step_ok;
    logic       w_block;

    assign w_en      = {cE, bE, aE};
    assign w_side    = {cH1_L0, bH1_L0, aH1_L0};
    assign w_step_ok = step_legal(m3step);

`ifdef MOTORO3_DT_FAULT_EN
    logic r_fault;
    logic w_fault_cond;
    logic w_fault_nxt;

    assign w_fault_cond = (&w_en) | ((|w_en) & ~w_step_ok);
    assign w_fault_nxt  = w_fault_cond | (r_fault & ~faultClr);

    always_ff @(negedge clk) begin
        if (!nRst) r_fault <= 1'b0;
        else       r_fault <= w_fault_nxt;
    end

    // Block on the value fault takes this edge, so gates drop in the same cycle fault rises.
    assign w_block = w_fault_nxt;
    assign fault   = r_fault;
`else
    logic w_unused_fault_clr;
    assign w_unused_fault_clr = faultClr;
    assign w_block = 1'b0;
    assign fault   = 1'b0;
`endif

    generate
        for (genvar p = 0; p < 3; p++) begin : g_phase
            phase_req_e w_req;
            assign w_req = (w_block || !w_step_ok) ? REQ_OFF
                                                   : decode_req(w_en[p], w_side[p], pwm);
            motoro3_deadtime_phase #(.DEADTIME(DEADTIME)) u_phase (
                .clk   (clk),
                .nRst  (nRst),
                .i_req (w_req),
                .o_hi  (w_hi[p]),
                .o_lo  (w_lo[p])
            );
        end
    endgenerate

    assign aHi = w_hi[0];
    assign aLo = w_lo[0];
    assign bHi = w_hi[1];
    assign bLo = w_lo[1];
    assign cHi = w_hi[2];
    assign cLo = w_lo[2];

endmodule

// File: tb/tb_motoro3_deadtime_gate.sv
// Directed scoreboard bench for motoro3_deadtime_gate plus a random stream overlap check.
module tb_motoro3_deadtime_gate;

`ifdef MOTORO3_DT_FAULT_EN
    localparam logic FEN = 1'b1;
`else
    localparam logic FEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic nRst, pwm, aE, bE, cE, aH, bH, cH, faultClr;
    logic [3:0] m3step;
    logic aHi, aLo, bHi, bLo, cHi, cLo, fault;

    typedef struct {
        string      name;
        logic [6:0] exp;
        int         due;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cycnt = 0;

    always #50 clk = ~clk;

    motoro3_deadtime_gate #(.DEADTIME(20)) dut (
        .clk(clk), .nRst(nRst), .pwm(pwm),
        .aE(aE), .bE(bE), .cE(cE),
        .aH1_L0(aH), .bH1_L0(bH), .cH1_L0(cH),
        .m3step(m3step), .faultClr(faultClr),
        .aHi(aHi), .aLo(aLo), .bHi(bHi), .bLo(bLo), .cHi(cHi), .cLo(cLo),
        .fault(fault)
    );

    always @(negedge clk) cycnt = cycnt + 1;

    // Monitor: outputs are stable at the rising edge, half a period after the DUT's edge.
    always @(posedge clk) begin : mon
        exp_t e;
        logic [6:0] act;
        act = {aHi, aLo, bHi, bLo, cHi, cLo, fault};
        checks++;
        if (((aHi & aLo) | (bHi & bLo) | (cHi & cLo)) === 1'b1) begin
            failures++;
            $display("FAIL overlap cyc=%0d gates=%b required no Hi&Lo pair", cycnt, act[6:1]);
        end
        while (q.size() > 0 && q[0].due <= cycnt) begin
            e = q.pop_front();
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%b expected=%b (aHi aLo bHi bLo cHi cLo fault)",
                         e.name, cycnt, act, e.exp);
            end
        end
    end

    task automatic cyc(input string nm, input logic [6:0] ex);
        exp_t e;
        e.name = nm;
        e.exp  = ex;
        e.due  = cycnt + 1;
        q.push_back(e);
        @(negedge clk); #5;
    endtask

    initial begin
        nRst = 1'b0; pwm = 1'b0; aE = 1'b0; bE = 1'b0; cE = 1'b0;
        aH = 1'b0; bH = 1'b0; cH = 1'b0; faultClr = 1'b0; m3step = 4'd0;
        @(negedge clk); #5;
        cyc("reset0", 7'b0000000);
        cyc("reset1", 7'b0000000);

        nRst = 1'b1; m3step = 4'd1; aE = 1'b1; aH = 1'b1; pwm = 1'b1; cE = 1'b1; cH = 1'b0;
        cyc("drive_aHi_cLo", 7'b1000010);
        cyc("hold_aHi_cLo", 7'b1000010);

        aH = 1'b0;
        repeat (20) cyc("a_dead_hi_to_lo", 7'b0000010);
        cyc("a_lo_after_dead", 7'b0100010);
        cyc("a_lo_hold", 7'b0100010);

        aH = 1'b1;
        repeat (20) cyc("a_dead_lo_to_hi", 7'b0000010);
        cyc("a_hi_after_dead", 7'b1000010);

        pwm = 1'b0;
        repeat (3) cyc("a_pwm_low", 7'b0000010);
        pwm = 1'b1;
        cyc("a_pwm_return", 7'b1000010);
        cyc("a_pwm_hold", 7'b1000010);

        aE = 1'b0;
        repeat (22) cyc("a_off_expire", 7'b0000010);
        aE = 1'b1; aH = 1'b0;
        cyc("a_lo_from_idle", 7'b0100010);

        m3step = 4'd0;
        cyc("step0_all_off", {6'b000000, FEN});

        nRst = 1'b0;
        cyc("reset_mid_dead", 7'b0000000);
        nRst = 1'b1; aE = 1'b0; cE = 1'b0; m3step = 4'd3; bE = 1'b1; bH = 1'b1;
        cyc("b_hi_step3", 7'b0010000);

        m3step = 4'd7;
        cyc("step7_b_off", {6'b000000, FEN});
        nRst = 1'b0;
        cyc("reset_b_dead", 7'b0000000);
        nRst = 1'b1; m3step = 4'd3; bH = 1'b0;
        cyc("b_lo_no_deadband", 7'b0001000);

        m3step = 4'd12;
        cyc("step12_off", {6'b000000, FEN});
        nRst = 1'b0;
        cyc("reset_again", 7'b0000000);
        nRst = 1'b1; m3step = 4'd6; bH = 1'b1;
        cyc("step6_b_hi", 7'b0010000);
        nRst = 1'b0; bE = 1'b0;
        cyc("reset_pre_fault", 7'b0000000);

`ifdef MOTORO3_DT_FAULT_EN
        nRst = 1'b1; m3step = 4'd1; pwm = 1'b1;
        aE = 1'b1; bE = 1'b1; cE = 1'b1; aH = 1'b1; bH = 1'b1; cH = 1'b0;
        cyc("fault_set", 7'b0000001);
        cyc("fault_hold", 7'b0000001);
        faultClr = 1'b1;
        cyc("fault_clr_blocked", 7'b0000001);
        bE = 1'b0; cE = 1'b0;
        cyc("fault_clr_resume", 7'b1000000);
        faultClr = 1'b0;
        cyc("resume_hold", 7'b1000000);
`endif

        for (int i = 0; i < 10000; i++) begin
            nRst     = ($urandom_range(0, 99) != 0);
            pwm      = $urandom_range(0, 1) != 0;
            aE       = $urandom_range(0, 1) != 0;
            bE       = $urandom_range(0, 1) != 0;
            cE       = $urandom_range(0, 1) != 0;
            aH       = $urandom_range(0, 1) != 0;
            bH       = $urandom_range(0, 1) != 0;
            cH       = $urandom_range(0, 1) != 0;
            faultClr = ($urandom_range(0, 7) == 0);
            m3step   = 4'($urandom_range(0, 15));
            @(negedge clk); #5;
        end

        nRst = 1'b0;
        cyc("final_reset", 7'b0000000);

        for (int g = 0; g < 10 && q.size() > 0; g++) @(posedge clk);
        #1;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motoro3_deadtime_gate.md
MOTORO3_DEADTIME_GATE -- requirements
Module: motoro3_deadtime_gate

Interface
REQ-001 Parameter DEADTIME, default 20, is the dead-band length in clk cycles (20 = 2 us at 10 MHz); legal range 1..255.
REQ-002 Port clk, input, 1 bit: 10 MHz system clock; all flops update on the falling edge, matching the commutation state machine.
REQ-003 Port nRst, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port pwm, input, 1 bit: chopping signal from the PWM generator.
REQ-005 Ports aE, bE, cE, inputs, 1 bit each: phase enable from the commutation state machine.
REQ-006 Ports aH1_L0, bH1_L0, cH1_L0, inputs, 1 bit each: drive side per phase (1 = high, 0 = low).
REQ-007 Port m3step, input, 4 bits: commutation step (0 idle, 1..6 normal, 7 force stop).
REQ-008 Port faultClr, input, 1 bit: clears the latched fault.
REQ-009 Ports aHi, aLo, bHi, bLo, cHi, cLo, outputs, 1 bit each, registered: gate drives.
REQ-010 Port fault, output, 1 bit, registered: latched shoot-through or illegal-pattern fault.

Function
REQ-011 Per-phase request SHALL be HI when E=1, H1_L0=1 and pwm=1; LO when E=1 and H1_L0=0 (pwm ignored); OFF otherwise.
REQ-012 Each phase SHALL run an FSM with states IDLE, DEAD, HI, LO, plus a lastSide bit and an 8-bit dead counter.
REQ-013 IDLE: request HI -> HI; request LO -> LO; request OFF -> stay in IDLE.
REQ-014 HI or LO: a request for the same side SHALL hold the state; any other request -> DEAD, counter loaded with DEADTIME-1, and lastSide records the side just left.
REQ-015 DEAD: counter decrements each cycle; a request equal to lastSide -> that side immediately; when the counter is 0 -> IDLE; an opposite-side request SHALL wait in DEAD until the counter reaches 0.
REQ-016 Outputs SHALL be Hi=1 only in HI and Lo=1 only in LO; latency from an input change to the gate output is exactly 1 clk edge.
REQ-017 An opposite-side transition SHALL produce exactly DEADTIME cycles with both gates 0 before the new gate asserts.
REQ-018 When m3step is 0, 7 or 8..15, all phases SHALL go to DEAD (or stay in IDLE) on the next edge, ignoring E and H1_L0.
REQ-019 Fault detection SHALL set fault when all three E inputs are 1, or when any phase has both E=1 with m3step outside 1..6.
REQ-020 While fault=1, all six gates SHALL be 0 and every phase FSM is held in DEAD/IDLE.
REQ-021 faultClr=1 SHALL clear fault on the next edge unless the fault condition is present in the same cycle, in which case fault stays 1.
REQ-022 Hi and Lo of one phase SHALL never be 1 in the same cycle under any input sequence.

Reset
REQ-023 While nRst=0 at a falling clk edge, every FSM SHALL go to IDLE, counters and lastSide to 0, all gates to 0, and fault to 0.
REQ-024 Reset asserted during DEAD or HI/LO SHALL abort immediately; after release, the first drive SHALL be permitted without dead band.

Configuration
REQ-025 Macro MOTORO3_DT_FAULT_EN: when defined, REQ-019..021 are implemented; when undefined, fault is tied to 0, faultClr is ignored, and REQ-018 and REQ-022 still hold.

Structure
REQ-026 Package motoro3_pkg SHALL hold the phase-state enum (IDLE/DEAD/HI/LO), the request codes (OFF/HI/LO), and the DEADTIME default constant.
REQ-027 Sub-module motoro3_deadtime_phase SHALL implement one phase FSM and counter and be instantiated three times; request decoding and the fault logic stay in the top level.

Verification
REQ-028 Reset, then m3step=1, aE=1, aH1_L0=1, pwm=1, cE=1, cH1_L0=0 -> aHi=1 and cLo=1 one edge later; all other gates 0.
REQ-029 DEADTIME=20, phase A at HI; switch aH1_L0 to 0 -> aHi=0 next edge, aLo=0 for exactly 20 cycles, then aLo=1.
REQ-030 Phase A at HI; toggle pwm 1->0->1 with 3 cycles low -> aHi drops for 3 cycles, returns without waiting DEADTIME; aLo stays 0 throughout.
REQ-031 aE=bE=cE=1 with MOTORO3_DT_FAULT_EN defined -> fault=1 next edge and all gates 0; faultClr=1 with a legal pattern -> fault=0, and drives resume via REQ-013.
REQ-032 m3step 3->7 while bHi=1 -> bHi=0 next edge; assert nRst=0 mid-DEAD -> all outputs 0; random 10k-cycle input stream -> REQ-022 never violated.
